scope_dma_sequencer: RTL and testbench

Sits between the scope sample stream and the PS DMA slave stream port. Cuts the continuous scope stream into fixed-length DMA buffers and drives tlast on each buffer's final beat. Holds off the source while the DMA finishes each buffer, then re-arms on dma_done. Flags a transfer that never completes.

---
 rtl/scope_dma_sequencer.sv | 119 +++++++++++
 tb/tb_scope_dma_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scope_dma_sequencer.sv
// Slices the continuous scope sample stream into fixed-length DMA buffers with tlast,
// holds the source off until the DMA reports completion, and flags completions that never arrive.
module scope_dma_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [COUNT_WIDTH-1:0] buffer_size,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_tlast,
    input  logic                   dma_done,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] transfer_count,
    output logic                   timeout_error
);

    // state      | meaning
    // ST_IDLE    | source held off, waiting for enable with a non-zero buffer_size
    // ST_STREAM  | zero-latency pass-through, counting beats up to size_q
    // ST_WAIT    | buffer handed off, source held off until dma_done or timeout
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    localparam int TO_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_WIDTH-1:0]    TO_LOAD = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_WIDTH-1:0]    TO_ONE  = TO_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    logic [1:0]             state;
    logic [COUNT_WIDTH-1:0] size_q;
    logic [COUNT_WIDTH-1:0] beat_cnt;
    logic [COUNT_WIDTH-1:0] xfer_cnt;
    logic [TO_WIDTH-1:0]    to_cnt;
    logic                   to_err;

    logic streaming;
    logic beat;
    logic at_last;
    logic start_ok;
    logic to_expired;

    always_comb begin
        streaming  = (state == ST_STREAM);
        out_valid  = streaming & in_valid;
        in_ready   = streaming & out_ready;
        out_data   = streaming ? in_data : '0;
        at_last    = (beat_cnt == (size_q - CNT_ONE));
        out_tlast  = out_valid & at_last;
        beat       = out_valid & out_ready;
        start_ok   = enable & (buffer_size != '0);
        to_expired = (to_cnt == '0);
    end

    assign busy           = (state != ST_IDLE);
    assign transfer_count = xfer_cnt;
    assign timeout_error  = to_err;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_IDLE;
            size_q   <= '0;
            beat_cnt <= '0;
            xfer_cnt <= '0;
            to_cnt   <= '0;
            to_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        size_q   <= buffer_size;
                        beat_cnt <= '0;
                        to_err   <= 1'b0;
                        state    <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (beat) begin
                        if (at_last) begin
                            beat_cnt <= '0;
                            to_cnt   <= TO_LOAD;
                            state    <= ST_WAIT;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_ONE;
                        end
                    end
                end
                ST_WAIT: begin
                    // dma_done takes priority over a timeout expiring in the same cycle
                    if (dma_done) begin
                        xfer_cnt <= xfer_cnt + CNT_ONE;
                        if (start_ok) begin
                            size_q   <= buffer_size;
                            beat_cnt <= '0;
                            state    <= ST_STREAM;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (to_expired) begin
                        to_err <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt - TO_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scope_dma_sequencer.sv
// Randomized bench for scope_dma_sequencer: a transaction-level model tracks stream order,
// buffer lengths, completed transfers and the timeout window.
module tb_scope_dma_sequencer;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [CW-1:0] buffer_size = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_tlast;
    logic          dma_done = 1'b0;
    logic          busy;
    logic [CW-1:0] transfer_count;
    logic          timeout_error;

    int errors = 0;
    int checks = 0;
    int exp_xfer = 0;
    int src_idx = 0;
    int exp_idx = 0;

    scope_dma_sequencer #(
        .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .buffer_size(buffer_size),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_tlast(out_tlast), .dma_done(dma_done), .busy(busy),
        .transfer_count(transfer_count), .timeout_error(timeout_error)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] data_of(input int i);
        return DW'(i) * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    // One buffer's worth of streaming; the caller judges the returned tallies.
    task automatic run_stream(input int len, input int rdy_pct, input int vld_pct, input int drop_after,
                              output int beats, output int bad_data, output int bad_tlast,
                              output int bad_hs, output int cycles);
        beats = 0; bad_data = 0; bad_tlast = 0; bad_hs = 0; cycles = 0;
        while (beats < len && cycles < 200) begin
            #1;
            in_valid    = ($urandom_range(1, 100) <= vld_pct);
            out_ready   = ($urandom_range(1, 100) <= rdy_pct);
            in_data     = data_of(src_idx);
            enable      = (beats < drop_after);
            buffer_size = CW'($urandom);
            dma_done    = ($urandom_range(0, 9) == 0);
            #1;
            if (out_valid !== in_valid || in_ready !== out_ready) bad_hs++;
            if (out_valid === 1'b1) begin
                if (out_tlast !== (beats + 1 == len)) bad_tlast++;
            end else if (out_tlast !== 1'b0) bad_tlast++;
            if (out_valid && out_ready) begin
                if (out_data !== data_of(exp_idx)) bad_data++;
                exp_idx++;
                beats++;
            end
            if (in_valid && in_ready) src_idx++;
            cycles++;
            @(posedge clock);
        end
        dma_done = 1'b0;
    endtask

    task automatic wait_check(input int n, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            dma_done  = 1'b0;
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            in_data   = CW'($urandom);
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_tlast !== 1'b0 || busy !== 1'b1) bad++;
            @(posedge clock);
        end
    endtask

    task automatic idle_cycles(input int n, input logic en, input logic [CW-1:0] bs, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            enable      = en;
            buffer_size = bs;
            dma_done    = 1'($urandom);
            in_valid    = 1'($urandom);
            out_ready   = 1'($urandom);
            in_data     = $urandom;
            #1;
            if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
                out_tlast !== 1'b0 || out_data !== '0) bad++;
            @(posedge clock);
        end
        dma_done = 1'b0;
    endtask

    task automatic start_buf(input logic [CW-1:0] bs);
        #1;
        enable      = 1'b1;
        buffer_size = bs;
        dma_done    = 1'b0;
        @(posedge clock);
    endtask

    task automatic pulse_done(input logic en, input logic [CW-1:0] bs);
        #1;
        enable      = en;
        buffer_size = bs;
        dma_done    = 1'b1;
        in_valid    = 1'($urandom);
        out_ready   = 1'($urandom);
        @(posedge clock);
        #1 dma_done = 1'b0;
    endtask

    task automatic test_reset;
        @(posedge clock);
        for (int c = 0; c < 3; c++) begin
            #1;
            enable = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
            dma_done = 1'($urandom); buffer_size = CW'($urandom); in_data = $urandom;
            #1;
            checks++;
            if ({in_ready, out_valid, out_tlast, busy, timeout_error} !== 5'b0) begin
                errors++;
                $display("FAIL reset_flags cycle %0d: got %b expected 00000", c,
                         {in_ready, out_valid, out_tlast, busy, timeout_error});
            end
            checks++;
            if (transfer_count !== '0 || out_data !== '0) begin
                errors++;
                $display("FAIL reset_values cycle %0d: count=%0d data=%h expected 0/0", c, transfer_count, out_data);
            end
            @(posedge clock);
        end
        #1;
        reset = 1'b1; enable = 1'b0; dma_done = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clock);
    endtask

    task automatic test_basic;
        int beats, bd, bt, bh, cyc, bw;
        start_buf(4);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_start busy=%b expected 1", busy); end
        for (int b = 0; b < 2; b++) begin
            run_stream(4, 100, 100, 1000, beats, bd, bt, bh, cyc);
            checks++;
            if (beats !== 4 || cyc !== 4) begin
                errors++; $display("FAIL basic_beats buf %0d: beats=%0d cycles=%0d expected 4/4", b, beats, cyc);
            end
            checks++;
            if (bd !== 0 || bt !== 0 || bh !== 0) begin
                errors++; $display("FAIL basic_stream buf %0d: data=%0d tlast=%0d hs=%0d errors expected 0", b, bd, bt, bh);
            end
            wait_check(5, bw);
            checks++;
            if (bw !== 0) begin errors++; $display("FAIL basic_wait buf %0d: %0d bad cycles expected 0", b, bw); end
            pulse_done(b == 0, 8'd4);
            exp_xfer++;
            checks++;
            if (transfer_count !== CW'(exp_xfer) || busy !== (b == 0)) begin
                errors++;
                $display("FAIL basic_done buf %0d: count=%0d busy=%b expected %0d/%b", b, transfer_count, busy,
                         exp_xfer, (b == 0));
            end
        end
    endtask

    task automatic test_backpressure;
        int beats, bd, bt, bh, cyc, bw;
        start_buf(8);
        for (int b = 0; b < 3; b++) begin
            run_stream(8, 50, 70, 1000, beats, bd, bt, bh, cyc);
            checks++;
            if (beats !== 8 || bd !== 0 || bt !== 0 || bh !== 0) begin
                errors++;
                $display("FAIL backpressure buf %0d: beats=%0d data=%0d tlast=%0d hs=%0d expected 8/0/0/0",
                         b, beats, bd, bt, bh);
            end
            wait_check($urandom_range(1, 4), bw);
            pulse_done(b < 2, 8'd8);
            exp_xfer++;
        end
        checks++;
        if (busy !== 1'b0 || transfer_count !== CW'(exp_xfer)) begin
            errors++;
            $display("FAIL backpressure_end: busy=%b count=%0d expected 0/%0d", busy, transfer_count, exp_xfer);
        end
    endtask

    task automatic test_enable_drop;
        int beats, bd, bt, bh, cyc, bw, bi;
        start_buf(6);
        run_stream(6, 80, 100, 2, beats, bd, bt, bh, cyc);
        checks++;
        if (beats !== 6 || bd !== 0 || bt !== 0 || bh !== 0) begin
            errors++;
            $display("FAIL enable_drop: beats=%0d data=%0d tlast=%0d hs=%0d expected 6/0/0/0", beats, bd, bt, bh);
        end
        wait_check(3, bw);
        pulse_done(1'b0, 8'd6);
        exp_xfer++;
        checks++;
        if (busy !== 1'b0 || transfer_count !== CW'(exp_xfer)) begin
            errors++;
            $display("FAIL enable_drop_done: busy=%b count=%0d expected 0/%0d", busy, transfer_count, exp_xfer);
        end
        idle_cycles(3, 1'b0, 8'd5, bi);
        checks++;
        if (bi !== 0) begin errors++; $display("FAIL enable_drop_idle: %0d bad cycles expected 0", bi); end
    endtask

    task automatic test_timeout;
        int beats, bd, bt, bh, cyc, n, early, bi;
        start_buf(3);
        run_stream(3, 100, 100, 0, beats, bd, bt, bh, cyc);
        n = 0; early = 0;
        while (n < 40) begin
            #1 dma_done = 1'b0;
            #1;
            if (busy !== 1'b1) break;
            if (timeout_error !== 1'b0) early++;
            n++;
            @(posedge clock);
        end
        checks++;
        if (n !== TO || early !== 0) begin
            errors++; $display("FAIL timeout_window: waited %0d cycles (early flag %0d) expected %0d", n, early, TO);
        end
        checks++;
        if (timeout_error !== 1'b1 || transfer_count !== CW'(exp_xfer)) begin
            errors++;
            $display("FAIL timeout_flag: err=%b count=%0d expected 1/%0d", timeout_error, transfer_count, exp_xfer);
        end
        @(posedge clock);
        idle_cycles(4, 1'b0, 8'd3, bi);
        pulse_done(1'b0, 8'd3);
        checks++;
        if (transfer_count !== CW'(exp_xfer) || timeout_error !== 1'b1 || busy !== 1'b0 || bi !== 0) begin
            errors++;
            $display("FAIL timeout_late_done: count=%0d err=%b busy=%b idle_bad=%0d expected %0d/1/0/0",
                     transfer_count, timeout_error, busy, bi, exp_xfer);
        end
        start_buf(2);
        #1;
        checks++;
        if (timeout_error !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL timeout_rearm: err=%b busy=%b expected 0/1", timeout_error, busy);
        end
        run_stream(2, 70, 70, 1000, beats, bd, bt, bh, cyc);
        pulse_done(1'b0, 8'd2);
        exp_xfer++;
        checks++;
        if (beats !== 2 || bd !== 0 || bt !== 0 || transfer_count !== CW'(exp_xfer)) begin
            errors++;
            $display("FAIL timeout_recover: beats=%0d data=%0d tlast=%0d count=%0d expected 2/0/0/%0d",
                     beats, bd, bt, transfer_count, exp_xfer);
        end
    endtask

    task automatic test_boundary;
        int beats, bd, bt, bh, cyc, bi;
        idle_cycles(5, 1'b1, 8'd0, bi);
        checks++;
        if (bi !== 0 || transfer_count !== CW'(exp_xfer)) begin
            errors++; $display("FAIL size_zero_idle: %0d bad cycles count=%0d expected 0/%0d", bi, transfer_count, exp_xfer);
        end
        start_buf(1);
        for (int b = 0; b < 4; b++) begin
            run_stream(1, 60, 60, 1000, beats, bd, bt, bh, cyc);
            checks++;
            if (beats !== 1 || bd !== 0 || bt !== 0 || bh !== 0) begin
                errors++;
                $display("FAIL size_one buf %0d: beats=%0d data=%0d tlast=%0d hs=%0d expected 1/0/0/0",
                         b, beats, bd, bt, bh);
            end
            pulse_done(1'b1, (b < 3) ? 8'd1 : 8'd0);
            exp_xfer++;
        end
        checks++;
        if (busy !== 1'b0 || transfer_count !== CW'(exp_xfer)) begin
            errors++;
            $display("FAIL relatch_zero: busy=%b count=%0d expected 0/%0d", busy, transfer_count, exp_xfer);
        end
    endtask

    task automatic one_beat(inout int bad);
        #1;
        in_valid = 1'b1; out_ready = 1'b1; dma_done = 1'b0; in_data = data_of(src_idx);
        #1;
        if (out_tlast !== 1'b1 || out_valid !== 1'b1 || out_data !== data_of(exp_idx)) bad++;
        if (out_valid && out_ready) exp_idx++;
        if (in_valid && in_ready) src_idx++;
        @(posedge clock);
    endtask

    task automatic test_wrap;
        int bad = 0;
        int guard = 0;
        start_buf(1);
        while ((exp_xfer % 256) != 255 && guard < 300) begin
            one_beat(bad);
            pulse_done(1'b1, 8'd1);
            exp_xfer++;
            guard++;
        end
        #1;
        checks++;
        if (transfer_count !== 8'hFF || bad !== 0) begin
            errors++; $display("FAIL wrap_preset: count=%0d beat_errs=%0d expected 255/0", transfer_count, bad);
        end
        one_beat(bad);
        pulse_done(1'b0, 8'd1);
        exp_xfer++;
        checks++;
        if (transfer_count !== 8'h00 || busy !== 1'b0 || bad !== 0) begin
            errors++;
            $display("FAIL wrap_zero: count=%0d busy=%b beat_errs=%0d expected 0/0/0", transfer_count, busy, bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_enable_drop();
        test_timeout();
        test_boundary();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
